multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have the port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port Reset, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have the port Instr, input, 32 bits: instruction word from instruction memory; sampled only while IR_LdEn=1.
REQ-004 The block SHALL have the port Zero, input, 1 bit: ALU zero flag; used only in state BRANCH.
REQ-005 The block SHALL have the port Mem_Ack, input, 1 bit: data-memory completion; ignored unless Mem_Req=1.
REQ-006 The block SHALL have the following 1-bit outputs, with the stated meanings:
- PC_Sel: 0=PC+4, 1=branch target.
- PC_LdEn: PC write.
- IR_LdEn: instruction-register load.
- RF_WrEn: register-file write.
- RF_WrData_sel: 0=memory, 1=ALU.
- RF_B_sel: RF read-B source select.
- ALU_Bin_sel: 0=register, 1=immediate.
- Mem_Req: data-memory request.
- Mem_WrEn: data-memory write.
- lb_MEM_trim: byte-load trim.
REQ-007 The block SHALL have the output ALU_func, 4 bits: ALU operation code.

Function
REQ-008 The block SHALL implement states IFETCH, DECODE, EXEC, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, encoded in a 4-bit state register.
REQ-009 In IFETCH the block SHALL assert IR_LdEn, latch opcode=Instr[31:26] and func=Instr[3:0] internally, and go to DECODE next cycle.
REQ-010 In DECODE the block SHALL branch on opcode as follows:
- 100000, 111000, 110000, 110010, 110011 -> EXEC.
- 001111, 000011, 011111 -> MEM_ADDR.
- 000000, 000001, 111111 -> BRANCH.
- Any other opcode -> IFETCH, with PC_LdEn=1, PC_Sel=0, and no RF or memory strobe (illegal instruction skipped).
REQ-011 The block SHALL use the following ALU_func values:
- 100000: func.
- 110010: 2.
- 110011: 3.
- 000000 and 000001: 1.
- All other opcodes: 0.
REQ-012 ALU_Bin_sel and RF_B_sel SHALL equal 1 for every opcode except 100000, where both are 0; for 000000 and 000001, RF_B_sel=1 and ALU_Bin_sel=0. Both SHALL be held stable from DECODE through the last state of the instruction.
REQ-013 In EXEC the block SHALL hold the ALU controls and go to ALU_WB next cycle.
REQ-014 In ALU_WB the block SHALL assert RF_WrEn=1, RF_WrData_sel=1 and PC_LdEn=1, then go to IFETCH.
REQ-015 From MEM_ADDR the block SHALL go to MEM_WR for opcode 011111, else to MEM_RD.
REQ-016 In MEM_RD the block SHALL assert Mem_Req=1 and remain in MEM_RD until Mem_Ack=1, then go to MEM_WB.
REQ-017 In MEM_WR the block SHALL assert Mem_Req=1 and Mem_WrEn=1 until Mem_Ack=1; in the Ack cycle it SHALL also assert PC_LdEn=1 and go to IFETCH.
REQ-018 In MEM_WB the block SHALL assert RF_WrEn=1, RF_WrData_sel=0, PC_LdEn=1 and lb_MEM_trim=(opcode==000011), then go to IFETCH.
REQ-019 In BRANCH the block SHALL assert PC_LdEn=1 and go to IFETCH, with PC_Sel combinational:
- 111111: PC_Sel=1.
- 000000: PC_Sel=Zero.
- 000001: PC_Sel=~Zero.
REQ-020 PC_LdEn SHALL be asserted exactly one cycle per instruction.
REQ-021 RF_WrEn and Mem_WrEn SHALL each be asserted at most one cycle per instruction.
REQ-022 A Mem_Ack arriving while Mem_Req=0 SHALL have no effect.
REQ-023 A Mem_Ack arriving in the same cycle as the first Mem_Req SHALL complete the access in that cycle.
REQ-024 Each output not named active in a state SHALL be 0 in that state.
REQ-025 Minimum latencies SHALL be: ALU/immediate 4 cycles, lw/lb 5, sw 4, branch 3; each Mem_Ack wait cycle adds 1.

Reset
REQ-026 While Reset=0, state SHALL be IFETCH, opcode/func SHALL be 0, and all outputs SHALL be 0 (IR_LdEn included).
REQ-027 Reset assertion mid-instruction, including while waiting on Mem_Ack, SHALL abort the instruction with no further strobes.
REQ-028 The first cycle after Reset deasserts SHALL be IFETCH with IR_LdEn=1.

Structure
REQ-029 Opcode constants, ALU_func codes and the state encoding SHALL reside in the shared package control_pkg.
REQ-030 The block SHALL be a single module with no sub-modules; next-state logic and output decode SHALL be separate processes.

Verification
REQ-031 Reset, then release with Instr=0x80000001 (ALU, func=1) -> controls in cycles 1..4 equal IR_LdEn; -; ALU_func=1; RF_WrEn=1 with PC_LdEn=1 in cycle 4.
REQ-032 lb (opcode 000011) with Mem_Ack delayed 3 cycles -> Mem_Req high 3 cycles; then MEM_WB with lb_MEM_trim=1, RF_WrEn=1, RF_WrData_sel=0; total 7 cycles.
REQ-033 beq with Zero=1, then beq with Zero=0, then bne with Zero=0 -> PC_Sel=1, 0, 1 respectively in BRANCH; PC_LdEn=1 each time.
REQ-034 sw with Mem_Ack=1 immediately -> Mem_Req=Mem_WrEn=PC_LdEn=1 in the same cycle; RF_WrEn never 1.
REQ-035 Opcode 0x2A -> return to IFETCH after DECODE with only PC_LdEn pulsed.
REQ-036 Reset=0 while in MEM_RD -> all outputs 0 immediately; next fetch proceeds normally after release.

Source files
------------

// File: rtl/control_pkg.sv
// Shared constants for the multicycle controller: state encoding, opcodes,
// ALU function codes and small opcode-class helpers.
package control_pkg;

  // Controller states, packed into a 4-bit register.
  typedef enum logic [3:0] {
    IFETCH   = 4'd0,
    DECODE   = 4'd1,
    EXEC     = 4'd2,
    ALU_WB   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WB   = 4'd6,
    MEM_WR   = 4'd7,
    BRANCH   = 4'd8
  } ctrlState_t;

  // Opcodes (Instr[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b100000;  // register ALU op, func selects operation
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;
  localparam logic [5:0] OP_B     = 6'b111111;

  // ALU function codes.
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;

  function automatic logic isExecOp(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LI) || (op == OP_ADDI) ||
           (op == OP_ANDI)  || (op == OP_ORI);
  endfunction

  function automatic logic isMemOp(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LB) || (op == OP_SW);
  endfunction

  function automatic logic isBranchOp(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_B);
  endfunction

  // ALU operation for a given opcode; register ops pass func through.
  function automatic logic [3:0] aluFuncFor(input logic [5:0] op, input logic [3:0] fn);
    case (op)
      OP_RTYPE:       return fn;
      OP_ANDI:        return ALU_AND;
      OP_ORI:         return ALU_OR;
      OP_BEQ, OP_BNE: return ALU_SUB;
      default:        return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle processor control unit: fetch/decode FSM that sequences ALU,
// load/store and branch instructions and drives datapath strobes.
module multicycle_control
  import control_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        Mem_Ack,
  output logic        PC_Sel,
  output logic        PC_LdEn,
  output logic        IR_LdEn,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        RF_B_sel,
  output logic        ALU_Bin_sel,
  output logic        Mem_Req,
  output logic        Mem_WrEn,
  output logic        lb_MEM_trim,
  output logic [3:0]  ALU_func
);

  ctrlState_t state, nextState;
  logic [5:0] opcode;
  logic [3:0] func;
  logic       legalOp;

  // Operand fields are decoded by the datapath, not here.
  logic unusedInstrBits;
  assign unusedInstrBits = ^Instr[25:4];

  assign legalOp = isExecOp(opcode) || isMemOp(opcode) || isBranchOp(opcode);

  // State register plus opcode/func latch captured during instruction fetch.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= IFETCH;
      opcode <= '0;
      func   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= nextState;
      if (IR_LdEn) begin
        opcode <= Instr[31:26];
        func   <= Instr[3:0];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path through the case leaves nextState unassigned (no latch).
    nextState = state;
    case (state)
      IFETCH: nextState = DECODE;
      DECODE: begin
        if (isExecOp(opcode))        nextState = EXEC;
        else if (isMemOp(opcode))    nextState = MEM_ADDR;
        else if (isBranchOp(opcode)) nextState = BRANCH;
        else                         nextState = IFETCH;  // illegal opcode skipped
      end
      EXEC:     nextState = ALU_WB;
      ALU_WB:   nextState = IFETCH;
      MEM_ADDR: nextState = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   if (Mem_Ack) nextState = MEM_WB;
      MEM_WB:   nextState = IFETCH;
      MEM_WR:   if (Mem_Ack) nextState = IFETCH;
      BRANCH:   nextState = IFETCH;
      default:  nextState = IFETCH;
    endcase
  end

  // Output decode; everything is forced low while reset is held so an abort
  // mid-instruction produces no further strobes.
  always_comb begin
    PC_Sel        = 1'b0;
    PC_LdEn       = 1'b0;
    IR_LdEn       = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_B_sel      = 1'b0;
    ALU_Bin_sel   = 1'b0;
    Mem_Req       = 1'b0;
    Mem_WrEn      = 1'b0;
    lb_MEM_trim   = 1'b0;
    ALU_func      = '0;

    if (Reset) begin
      // ALU controls are held from DECODE to the instruction's last state.
      if (state != IFETCH && legalOp) begin
        ALU_func    = aluFuncFor(opcode, func);
        RF_B_sel    = (opcode != OP_RTYPE);
        ALU_Bin_sel = !((opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_BNE));
      end

      case (state)
        IFETCH: IR_LdEn = 1'b1;
        DECODE: if (!legalOp) PC_LdEn = 1'b1;
        ALU_WB: begin
          RF_WrEn       = 1'b1;
          RF_WrData_sel = 1'b1;
          PC_LdEn       = 1'b1;
        end
        MEM_RD: Mem_Req = 1'b1;
        MEM_WB: begin
          RF_WrEn     = 1'b1;
          PC_LdEn     = 1'b1;
          lb_MEM_trim = (opcode == OP_LB);
        end
        MEM_WR: begin
          Mem_Req  = 1'b1;
          Mem_WrEn = 1'b1;
          PC_LdEn  = Mem_Ack;
        end
        BRANCH: begin
          PC_LdEn = 1'b1;
          case (opcode)
            OP_B:    PC_Sel = 1'b1;
            OP_BEQ:  PC_Sel = Zero;
            OP_BNE:  PC_Sel = ~Zero;
            default: PC_Sel = 1'b0;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control. All outputs are packed
// into one vector and compared cycle by cycle, 1 ns after each rising edge.
module tb_multicycle_control;

  logic        Clk, Reset, Zero, Mem_Ack;
  logic [31:0] Instr;
  logic        PC_Sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel;
  logic        ALU_Bin_sel, Mem_Req, Mem_WrEn, lb_MEM_trim;
  logic [3:0]  ALU_func;

  int nChecks = 0;
  int nFails  = 0;

  // Bit positions inside the packed control vector.
  localparam logic [13:0] PCSEL = 14'h2000;
  localparam logic [13:0] PCLD  = 14'h1000;
  localparam logic [13:0] IRLD  = 14'h0800;
  localparam logic [13:0] RFWR  = 14'h0400;
  localparam logic [13:0] RFWD  = 14'h0200;
  localparam logic [13:0] RFB   = 14'h0100;
  localparam logic [13:0] BIN   = 14'h0080;
  localparam logic [13:0] MREQ  = 14'h0040;
  localparam logic [13:0] MWR   = 14'h0020;
  localparam logic [13:0] TRIM  = 14'h0010;

  logic [13:0] ctrl;
  assign ctrl = {PC_Sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel,
                 ALU_Bin_sel, Mem_Req, Mem_WrEn, lb_MEM_trim, ALU_func};

  multicycle_control dut (
    .Clk(Clk), .Reset(Reset), .Instr(Instr), .Zero(Zero), .Mem_Ack(Mem_Ack),
    .PC_Sel(PC_Sel), .PC_LdEn(PC_LdEn), .IR_LdEn(IR_LdEn), .RF_WrEn(RF_WrEn),
    .RF_WrData_sel(RF_WrData_sel), .RF_B_sel(RF_B_sel), .ALU_Bin_sel(ALU_Bin_sel),
    .Mem_Req(Mem_Req), .Mem_WrEn(Mem_WrEn), .lb_MEM_trim(lb_MEM_trim),
    .ALU_func(ALU_func)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reset held: every output low, including IR_LdEn, regardless of inputs.
  task automatic test_reset();
    Instr = 32'h8000_0001; Mem_Ack = 1'b1; Zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      nChecks++;
      if (ctrl !== 14'h0) begin
        nFails++;
        $display("FAIL reset cycle %0d: got %h expected %h", i, ctrl, 14'h0);
      end
    end
    Mem_Ack = 1'b0; Zero = 1'b0;
    Reset = 1'b1;
    #1;
  endtask

  // Register ALU op: IFETCH, DECODE, EXEC, ALU_WB; func passes to ALU_func.
  task automatic test_alu(input logic [3:0] fn);
    logic [13:0] e [4];
    e = '{IRLD, {10'h0, fn}, {10'h0, fn}, RFWR | RFWD | PCLD | {10'h0, fn}};
    Instr = {6'b100000, 22'h0, fn};
    for (int i = 0; i < 4; i++) begin
      nChecks++;
      if (ctrl !== e[i]) begin
        nFails++;
        $display("FAIL alu func=%0d cycle %0d: got %h expected %h", fn, i + 1, ctrl, e[i]);
      end
      tick();
      Instr = 32'hFFFF_FFF0;  // junk after fetch must not be latched
    end
  endtask

  // Immediate ALU op (andi): selects high, ALU_func=2.
  task automatic test_alu_imm();
    logic [13:0] e [4];
    e = '{IRLD, RFB | BIN | 14'h2, RFB | BIN | 14'h2, RFWR | RFWD | PCLD | RFB | BIN | 14'h2};
    Instr = {6'b110010, 26'h3FF_FFF5};
    for (int i = 0; i < 4; i++) begin
      nChecks++;
      if (ctrl !== e[i]) begin
        nFails++;
        $display("FAIL andi cycle %0d: got %h expected %h", i + 1, ctrl, e[i]);
      end
      tick();
      Instr = 32'h0000_0000;
    end
  endtask

  // lb with stray Ack before the request and a 3-cycle request; 7 cycles total.
  task automatic test_lb_wait();
    logic [13:0] e [7];
    logic        ack [7];
    e   = '{IRLD, RFB | BIN, RFB | BIN, MREQ | RFB | BIN, MREQ | RFB | BIN,
            MREQ | RFB | BIN, RFWR | PCLD | TRIM | RFB | BIN};
    ack = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    Instr = {6'b000011, 26'h0};
    for (int i = 0; i < 7; i++) begin
      Mem_Ack = ack[i];
      #1;
      nChecks++;
      if (ctrl !== e[i]) begin
        nFails++;
        $display("FAIL lb cycle %0d: got %h expected %h", i + 1, ctrl, e[i]);
      end
      tick();
    end
    Mem_Ack = 1'b0;
  endtask

  // sw with immediate Ack: request, write and PC load all in one cycle.
  task automatic test_sw_fast();
    logic [13:0] e [4];
    e = '{IRLD, RFB | BIN, RFB | BIN, MREQ | MWR | PCLD | RFB | BIN};
    Instr = {6'b011111, 26'h0};
    for (int i = 0; i < 4; i++) begin
      Mem_Ack = (i == 3);
      #1;
      nChecks++;
      if (ctrl !== e[i]) begin
        nFails++;
        $display("FAIL sw cycle %0d: got %h expected %h", i + 1, ctrl, e[i]);
      end
      tick();
    end
    Mem_Ack = 1'b0;
  endtask

  // Branches: beq Z=1, beq Z=0, bne Z=0, unconditional b.
  task automatic test_branches();
    logic [5:0]  ops [4];
    logic        zs [4];
    logic [13:0] dec [4];
    logic [13:0] br [4];
    ops = '{6'b000000, 6'b000000, 6'b000001, 6'b111111};
    zs  = '{1'b1, 1'b0, 1'b0, 1'b0};
    dec = '{RFB | 14'h1, RFB | 14'h1, RFB | 14'h1, RFB | BIN};
    br  = '{PCSEL | PCLD | RFB | 14'h1, PCLD | RFB | 14'h1,
            PCSEL | PCLD | RFB | 14'h1, PCSEL | PCLD | RFB | BIN};
    for (int b = 0; b < 4; b++) begin
      Instr = {ops[b], 26'h0};
      Zero  = ~zs[b];
      #1;
      nChecks++;
      if (ctrl !== IRLD) begin
        nFails++;
        $display("FAIL branch %0d fetch: got %h expected %h", b, ctrl, IRLD);
      end
      tick();
      nChecks++;
      if (ctrl !== dec[b]) begin
        nFails++;
        $display("FAIL branch %0d decode: got %h expected %h", b, ctrl, dec[b]);
      end
      tick();
      Zero = zs[b];
      #1;
      nChecks++;
      if (ctrl !== br[b]) begin
        nFails++;
        $display("FAIL branch %0d exec: got %h expected %h", b, ctrl, br[b]);
      end
      tick();
    end
    Zero = 1'b0;
  endtask

  // Illegal opcode 0x2A: DECODE pulses only PC_LdEn, then fetch again.
  task automatic test_illegal();
    Instr = {6'h2A, 26'h0};
    #1;
    nChecks++;
    if (ctrl !== IRLD) begin
      nFails++;
      $display("FAIL illegal fetch: got %h expected %h", ctrl, IRLD);
    end
    tick();
    nChecks++;
    if (ctrl !== PCLD) begin
      nFails++;
      $display("FAIL illegal decode: got %h expected %h", ctrl, PCLD);
    end
    tick();
    nChecks++;
    if (ctrl !== IRLD) begin
      nFails++;
      $display("FAIL illegal refetch: got %h expected %h", ctrl, IRLD);
    end
  endtask

  // Reset while waiting in MEM_RD: outputs drop at once, fetch resumes cleanly.
  task automatic test_reset_in_mem_rd();
    logic [13:0] e [4];
    e = '{IRLD, RFB | BIN, RFB | BIN, MREQ | RFB | BIN};
    Instr = {6'b001111, 26'h0};
    for (int i = 0; i < 4; i++) begin
      nChecks++;
      if (ctrl !== e[i]) begin
        nFails++;
        $display("FAIL lw-abort cycle %0d: got %h expected %h", i + 1, ctrl, e[i]);
      end
      if (i < 3) tick();
    end
    #2;
    Reset = 1'b0;
    #1;
    nChecks++;
    if (ctrl !== 14'h0) begin
      nFails++;
      $display("FAIL abort immediate: got %h expected %h", ctrl, 14'h0);
    end
    Mem_Ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      nChecks++;
      if (ctrl !== 14'h0) begin
        nFails++;
        $display("FAIL abort held cycle %0d: got %h expected %h", i, ctrl, 14'h0);
      end
    end
    Mem_Ack = 1'b0;
    Reset = 1'b1;
    #1;
    test_alu(4'd5);
  endtask

  initial begin
    Reset = 1'b1; Instr = '0; Zero = 1'b0; Mem_Ack = 1'b0;
    #2 Reset = 1'b0;
    test_reset();
    test_alu(4'd1);
    test_alu_imm();
    test_lb_wait();
    test_sw_fast();
    test_branches();
    test_illegal();
    test_reset_in_mem_rd();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
